// File: rtl/proc_pkg.sv
// Shared types and constants for the 8-bit accumulator processor.
package proc_pkg;
  localparam int IW  = 9;
  localparam int PCW = 10;
  localparam int DW  = 8;
  localparam int DAW = 8;

  localparam logic [IW-1:0] HALT_INSN = 9'b111111111;

  typedef enum logic [2:0] {
    OP_ALU = 3'b000,
    OP_MOV = 3'b001,
    OP_LDI = 3'b010,
    OP_LD  = 3'b011,
    OP_ST  = 3'b100,
    OP_BZ  = 3'b101,
    OP_BNZ = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    F_ADD = 3'b000,
    F_SUB = 3'b001,
    F_AND = 3'b010,
    F_OR  = 3'b011,
    F_XOR = 3'b100,
    F_SHL = 3'b101,
    F_SHR = 3'b110,
    F_CMP = 3'b111
  } funct_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } run_state_e;

  // Branch/jump offsets are 6-bit two's complement, widened to the PC.
  function automatic logic [PCW-1:0] sext_off(input logic [5:0] imm);
    return {{(PCW-6){imm[5]}}, imm};
  endfunction
endpackage

// File: rtl/proc_alu.sv
// Combinational ALU; zero reflects the raw result, which CMP uses as its flag.
module proc_alu
  import proc_pkg::*;
(
  input  funct_e        op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y,
  output logic          zero
);
  always_comb begin
    y = '0;
    case (op)
      F_ADD:        y = a + b;
      F_SUB, F_CMP: y = a - b;
      F_AND:        y = a & b;
      F_OR:         y = a | b;
      F_XOR:        y = a ^ b;
      F_SHL:        y = a << b[2:0];
      F_SHR:        y = a >> b[2:0];
      default:      y = '0;
    endcase
  end

  assign zero = (y == '0);
endmodule

// File: rtl/proc_dram.sv
// Data memory: combinational read, write on the rising edge.
module proc_dram
  import proc_pkg::*;
(
  input  logic           clk,
  input  logic           we,
  input  logic [DAW-1:0] addr,
  input  logic [DW-1:0]  wdata,
  output logic [DW-1:0]  rdata
);
  logic [DW-1:0] core [0:(1<<DAW)-1];

  assign rdata = core[addr];

  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end
endmodule

// File: rtl/proc_irom.sv
// Instruction memory; read is combinational, the load port lets a host fill it.
module proc_irom
  import proc_pkg::*;
(
  input  logic           clk,
  input  logic           we,
  input  logic [PCW-1:0] waddr,
  input  logic [IW-1:0]  wdata,
  input  logic [PCW-1:0] addr,
  output logic [IW-1:0]  data
);
  logic [IW-1:0] core [0:(1<<PCW)-1];

  assign data = core[addr];

  always_ff @(posedge clk) begin
    if (we) core[waddr] <= wdata;
  end
endmodule

// File: rtl/top_level_proc.sv
// Single-cycle accumulator processor with its own instruction and data memories.
// req is a synchronous reset/start; done goes high on the edge that executes HALT.
module top_level_proc
  import proc_pkg::*;
(
  input  logic clk,
  input  logic req,
  output logic done
);
  localparam logic [PCW-1:0] PC_STEP = 1;

  logic [PCW-1:0] pc, pc_next;
  logic [DW-1:0]  regs [8];
  logic           z, z_next;
  run_state_e     state, state_next;

  logic [IW-1:0]  insn;
  opcode_e        op;
  funct_e         fn;
  logic [2:0]     rs;
  logic [5:0]     imm;
  logic [DW-1:0]  rs_val, dm_rdata, alu_y, r0_wdata;
  logic           alu_zero, r0_we, rx_we, dm_we;

  assign op     = opcode_e'(insn[8:6]);
  assign fn     = funct_e'(insn[5:3]);
  assign rs     = insn[2:0];
  assign imm    = insn[5:0];
  assign rs_val = regs[rs];

  proc_irom ir1 (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .addr  (pc),
    .data  (insn)
  );

  proc_dram dm1 (
    .clk   (clk),
    .we    (dm_we),
    .addr  (rs_val),
    .wdata (regs[0]),
    .rdata (dm_rdata)
  );

  proc_alu alu1 (
    .op   (fn),
    .a    (regs[0]),
    .b    (rs_val),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_comb begin
    pc_next    = pc + PC_STEP;
    state_next = state;
    r0_we      = 1'b0;
    r0_wdata   = alu_y;
    rx_we      = 1'b0;
    dm_we      = 1'b0;
    z_next     = z;
    if (state == ST_HALT) begin
      pc_next = pc;
    end else begin
      case (op)
        OP_ALU: begin
          if (fn == F_CMP) z_next = alu_zero;
          else r0_we = 1'b1;
        end
        OP_MOV: begin
          if (insn[5]) begin
            rx_we = (rs != 3'd0);
          end else begin
            r0_we    = 1'b1;
            r0_wdata = rs_val;
          end
        end
        OP_LDI: begin
          r0_we    = 1'b1;
          r0_wdata = {2'b00, imm};
        end
        OP_LD: begin
          r0_we    = 1'b1;
          r0_wdata = dm_rdata;
        end
        // The RAM sits outside the reset path, so an aborting req must gate the store here.
        OP_ST:  dm_we = !req;
        OP_BZ:  if (z) pc_next = pc + sext_off(imm);
        OP_BNZ: if (!z) pc_next = pc + sext_off(imm);
        OP_JMP: begin
          if (insn == HALT_INSN) begin
            pc_next    = pc;
            state_next = ST_HALT;
          end else begin
            pc_next = pc + sext_off(imm);
          end
        end
        default: ;
      endcase
    end
    if (r0_we) z_next = (r0_wdata == '0);
  end

  always_ff @(posedge clk) begin
    if (req) begin
      pc    <= '0;
      state <= ST_RUN;
      done  <= 1'b0;
      z     <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      pc    <= pc_next;
      state <= state_next;
      done  <= (state_next == ST_HALT);
      z     <= z_next;
      if (r0_we) regs[0] <= r0_wdata;
      if (rx_we) regs[rs] <= regs[0];
    end
  end
endmodule

// File: tb/tb_top_level_proc.sv
// Directed programs for top_level_proc with hand-computed results.
module tb_top_level_proc;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic req = 1'b1;
  logic done;

  int n_checks = 0;
  int n_fail   = 0;
  int pp       = 0;
  int cyc      = 0;
  logic all_high;
  logic [31:0] exp_q[$];

  top_level_proc dut (
    .clk  (clk),
    .req  (req),
    .done (done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_mem(input string tag, input int base, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_dm%0d", tag, base + i), 32'(dut.dm1.core[base + i]), exp_q.pop_front());
  endtask

  // ---------------- assembler ----------------
  function automatic logic [8:0] e_alu(input funct_e f, input int rs);
    return {3'b000, f, 3'(rs)};
  endfunction
  function automatic logic [8:0] e_movto(input int rs);  // r0 <= r[rs]
    return {3'b001, 3'b000, 3'(rs)};
  endfunction
  function automatic logic [8:0] e_movfr(input int rs);  // r[rs] <= r0
    return {3'b001, 3'b100, 3'(rs)};
  endfunction
  function automatic logic [8:0] e_ldi(input int v);
    return {3'b010, 6'(v)};
  endfunction
  function automatic logic [8:0] e_ld(input int rs);
    return {3'b011, 3'b000, 3'(rs)};
  endfunction
  function automatic logic [8:0] e_st(input int rs);
    return {3'b100, 3'b000, 3'(rs)};
  endfunction
  function automatic logic [8:0] e_bz(input int off);
    return {3'b101, 6'(off)};
  endfunction
  function automatic logic [8:0] e_bnz(input int off);
    return {3'b110, 6'(off)};
  endfunction
  function automatic logic [8:0] e_jmp(input int off);
    return {3'b111, 6'(off)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) dut.ir1.core[i] = HALT_INSN;
    pp = 0;
  endtask

  task automatic emit(input logic [8:0] w);
    dut.ir1.core[pp] = w;
    pp++;
  endtask

  task automatic start_prog();
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(posedge clk);
      cycles++;
      #1;
      if (done) break;
    end
    check({tag, "_done"}, 32'(done), 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, 32'(dut.pc), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_z"}, 32'(dut.z), 0);
    check({tag, "_state"}, 32'(dut.state), 32'(ST_RUN));
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(dut.regs[i]), 0);
  endtask

  task automatic load_count_loop();
    clear_prog();
    emit(e_ldi(1));  emit(e_movfr(1));
    emit(e_ldi(50)); emit(e_movfr(2));
    emit(e_ldi(10)); emit(e_movfr(3));
    emit(e_ld(2));   emit(e_alu(F_ADD, 1)); emit(e_st(2));
    emit(e_movto(3)); emit(e_alu(F_SUB, 1)); emit(e_movfr(3));
    emit(e_bnz(-6));
    emit(HALT_INSN);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_reset_state("reset");

    // Test 1: straight-line arithmetic and store
    clear_prog();
    emit(e_ldi(5));  emit(e_movfr(1)); emit(e_ldi(3)); emit(e_alu(F_ADD, 1));
    emit(e_movfr(2)); emit(e_ldi(40)); emit(e_movfr(3)); emit(e_movto(2));
    emit(e_st(3));   emit(HALT_INSN);
    dut.dm1.core[40] = 8'h00;
    start_prog();
    run_to_done("t1", 50, cyc);
    check("t1_cycles", 32'(cyc), 10);
    check("t1_dm40", 32'(dut.dm1.core[40]), 8);
    check("t1_r1", 32'(dut.regs[1]), 5);
    check("t1_r3", 32'(dut.regs[3]), 40);

    // Test 6: halted state holds, then a second req restarts
    all_high = 1'b1;
    repeat (100) @(negedge clk) if (!done) all_high = 1'b0;
    check("t6_done_held", 32'(all_high), 1);
    check("t6_pc_held", 32'(dut.pc), 9);
    check("t6_state", 32'(dut.state), 32'(ST_HALT));
    check("t6_dm40", 32'(dut.dm1.core[40]), 8);
    @(negedge clk) req = 1'b1;
    @(negedge clk);
    check("t6_done_drop", 32'(done), 0);
    req = 1'b0;
    run_to_done("t6", 50, cyc);
    check("t6_cycles", 32'(cyc), 10);

    // Test 2: BNZ loop incrementing a memory counter
    load_count_loop();
    dut.dm1.core[50] = 8'h00;
    start_prog();
    run_to_done("t2", 500, cyc);
    check("t2_cycles", 32'(cyc), 77);
    check("t2_counter", 32'(dut.dm1.core[50]), 10);
    check("t2_z", 32'(dut.z), 1);
    check("t2_r0", 32'(dut.regs[0]), 0);

    // Test 5: abort mid-loop on the cycle of a store, then rerun
    dut.dm1.core[50] = 8'h00;
    start_prog();
    repeat (29) @(posedge clk);
    @(negedge clk) req = 1'b1;
    @(negedge clk);
    check_reset_state("t5");
    check("t5_dm50_kept", 32'(dut.dm1.core[50]), 3);
    req = 1'b0;
    run_to_done("t5", 500, cyc);
    check("t5_cycles", 32'(cyc), 77);
    check("t5_counter", 32'(dut.dm1.core[50]), 13);

    // Test 3: shifts, logic ops and CMP
    clear_prog();
    emit(e_ldi(3));  emit(e_movfr(1)); emit(e_ldi(1)); emit(e_movfr(2));
    emit(e_ldi(0));  emit(e_alu(F_SUB, 2)); emit(e_movfr(3));
    emit(e_ldi(15)); emit(e_movfr(4));
    emit(e_ldi(60)); emit(e_movfr(5)); emit(e_ldi(61)); emit(e_movfr(6));
    emit(e_ldi(62)); emit(e_movfr(7));
    emit(e_ldi(21)); emit(e_alu(F_SHL, 1)); emit(e_st(5));
    emit(e_alu(F_XOR, 3)); emit(e_st(6));
    emit(e_alu(F_SHR, 2)); emit(e_st(7));
    emit(e_movfr(2)); emit(e_alu(F_AND, 4)); emit(e_movfr(1));
    emit(e_ldi(63)); emit(e_movfr(5)); emit(e_movto(1)); emit(e_st(5));
    emit(e_movto(2)); emit(e_alu(F_OR, 4)); emit(e_movfr(1));
    emit(e_ldi(59)); emit(e_movfr(5)); emit(e_movto(1)); emit(e_st(5));
    emit(e_alu(F_CMP, 1));
    emit(HALT_INSN);
    start_prog();
    run_to_done("t3", 200, cyc);
    check("t3_cycles", 32'(cyc), 38);
    exp_q.push_back(32'h2F);
    exp_q.push_back(32'hA8);
    exp_q.push_back(32'h57);
    exp_q.push_back(32'h2B);
    exp_q.push_back(32'h0B);
    check_mem("t3", 59, 5);
    check("t3_r0_after_cmp", 32'(dut.regs[0]), 32'h2F);
    check("t3_z_cmp", 32'(dut.z), 1);

    // Test 4: 5-bit pattern counting over dm[0..31]
    for (int i = 0; i < 32; i++) dut.dm1.core[i] = 8'b01010101;
    dut.dm1.core[32] = {5'b10101, 3'b000};
    for (int i = 33; i < 36; i++) dut.dm1.core[i] = 8'h00;
    clear_prog();
    emit(e_ldi(3));  emit(e_movfr(7)); emit(e_ldi(32)); emit(e_movfr(6));
    emit(e_ld(6));   emit(e_alu(F_SHR, 7)); emit(e_movfr(5));
    emit(e_ldi(31)); emit(e_movfr(4)); emit(e_ldi(1)); emit(e_movfr(6));
    emit(e_ldi(0));  emit(e_movfr(1));
    emit(e_ldi(0));  emit(e_movfr(3)); emit(e_movfr(2));                     // 13
    emit(e_ld(1));   emit(e_alu(F_SHR, 2)); emit(e_alu(F_AND, 4));          // 16
    emit(e_alu(F_CMP, 5)); emit(e_bnz(7));
    emit(e_movfr(3)); emit(e_ldi(33)); emit(e_movfr(7)); emit(e_ld(7));
    emit(e_alu(F_ADD, 6)); emit(e_st(7));
    emit(e_movto(2)); emit(e_alu(F_ADD, 6)); emit(e_movfr(2));              // 27
    emit(e_ldi(4));  emit(e_alu(F_CMP, 2)); emit(e_bnz(-16));
    emit(e_movto(3)); emit(e_bz(8));                                        // 33
    emit(e_ldi(34)); emit(e_movfr(7)); emit(e_ld(7)); emit(e_alu(F_ADD, 6));
    emit(e_st(7));   emit(e_jmp(2)); emit(e_jmp(-28));                      // 41
    emit(e_ldi(31)); emit(e_alu(F_CMP, 1)); emit(e_bz(31));                 // 42
    emit(e_ldi(4));  emit(e_movfr(2));
    emit(e_ldi(8));  emit(e_alu(F_SUB, 2)); emit(e_movfr(7));               // 47
    emit(e_movto(1)); emit(e_alu(F_ADD, 6)); emit(e_movfr(3)); emit(e_ld(3));
    emit(e_alu(F_SHL, 7)); emit(e_movfr(3));
    emit(e_ld(1));   emit(e_alu(F_SHR, 2)); emit(e_alu(F_OR, 3));           // 56
    emit(e_alu(F_AND, 4)); emit(e_alu(F_CMP, 5)); emit(e_bnz(8));
    emit(e_ldi(35)); emit(e_movfr(7)); emit(e_ld(7)); emit(e_alu(F_ADD, 6));
    emit(e_st(7));   emit(e_jmp(2)); emit(e_jmp(-27));                      // 68
    emit(e_movto(2)); emit(e_alu(F_ADD, 6)); emit(e_movfr(2));              // 69
    emit(e_ldi(8));  emit(e_alu(F_CMP, 2)); emit(e_bnz(-27));
    emit(e_movto(1)); emit(e_alu(F_ADD, 6)); emit(e_movfr(1));              // 75
    emit(e_ldi(32)); emit(e_alu(F_CMP, 1)); emit(e_bz(2)); emit(e_jmp(-13));
    emit(e_ldi(33)); emit(e_movfr(7)); emit(e_ld(7)); emit(e_movfr(3));     // 82
    emit(e_ldi(35)); emit(e_movfr(7)); emit(e_ld(7)); emit(e_alu(F_ADD, 3));
    emit(e_st(7));
    emit(HALT_INSN);                                                        // 91
    start_prog();
    run_to_done("t4", 20000, cyc);
    exp_q.push_back(64);
    exp_q.push_back(32);
    exp_q.push_back(126);
    check_mem("t4", 33, 3);
    check("t4_dm0_kept", 32'(dut.dm1.core[0]), 32'h55);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/top_level_proc.md
Name: top_level_proc

Overview:
- Minimal single-cycle 8-bit accumulator processor. Contains its own instruction memory and data memory.
- A program is preloaded into instruction memory and operands into data memory. A req pulse resets the core and starts it at PC 0; done rises when a HALT executes.
- Serves as the top of the design. Benches poke and peek memories hierarchically through instances ir1 and dm1.

Parameters:
- IW, 9, instruction width.
- PCW, 10, program counter width (1024-entry instruction memory).
- DW, 8, data and register width.
- DAW, 8, data address width (256-byte data memory).

Ports:
- clk  input  1  rising-edge clock.
- req  input  1  synchronous active-high reset and start request.
- done  output  1  program finished; high from the cycle after HALT until the next req.

Behaviour:
- Required hierarchy:
  - Instance ir1 contains an unpacked array core[1024] of 9-bit words, loadable by $readmemb.
  - Instance dm1 contains an array core[256] of 8 bits.
  - Both arrays are hierarchically writable and readable.
- Reset: while req=1 on a clock edge, the next state is:
  - PC=0, r0..r7=0, Z=0, done=0, halted=0.
  - Memory contents are untouched.
- Execution: one instruction per cycle, starting the first edge after req falls.
  - Instruction and data reads are combinational.
  - Register, flag, PC and memory writes happen on the rising edge.
- Encoding: op=[8:6], f=[5:3], rs=[2:0], imm6=[5:0].
  - 000 ALU: r0 <= r0 op r[rs].
    - f: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
    - 101 SHL by r[rs][2:0] (logical), 110 SHR by r[rs][2:0] (logical).
    - 111 CMP: computes r0-r[rs], sets Z only, r0 unchanged.
    - Results are mod 256; carry is discarded.
  - 001 MOV: if [5]=0, r0 <= r[rs]; if [5]=1, r[rs] <= r0. [4:3] ignored.
  - 010 LDI: r0 <= zero-extended imm6.
  - 011 LD: r0 <= dm[r[rs]].
  - 100 ST: dm[r[rs]] <= r0.
  - 101 BZ: if Z, PC <= PC + sext(imm6), else PC+1.
  - 110 BNZ: if !Z, PC <= PC + sext(imm6), else PC+1.
  - 111 with imm6=111111: HALT. Any other imm6: unconditional jump, PC <= PC + sext(imm6).
- Z flag: updated on every write to r0, set when the new r0 == 0. Also updated by CMP. Otherwise Z holds.
- Register r0 written via MOV with [5]=1 and rs=0: it is a no-op, and Z does not change.
- PC arithmetic wraps mod 1024. A branch offset of 0 is a legal self-loop.
- HALT:
  - halted and done are set on that edge; PC holds.
  - While halted, no state changes except through req.
  - done stays high indefinitely until req.
- req mid-program: aborts immediately, with the same reset state as above. A store issued in the cycle req is high is suppressed.
- done is a registered output and glitch-free.

Decomposition:
- Shared package proc_pkg holds:
  - Opcode and funct enums.
  - IW/PCW/DW/DAW constants.
  - HALT encoding constant 9'b111111111.
- Sub-modules are the instruction ROM (instance ir1) and data RAM (instance dm1).
- One natural combinational sub-module: alu (op select, two 8-bit operands, 8-bit result, zero output).

Test Plan:
1. Program: LDI 5; MOV r1<=r0; LDI 3; ADD r1; MOV r2<=r0; LDI 40; MOV r3<=r0; MOV r0<=r2; ST [r3]; HALT. Pulse req one cycle -> done rises 10 cycles after req falls; dm[40]=8.
2. Loop with BNZ counting r0 from 10 down to 0, incrementing a memory counter each pass -> counter=10 at done. Also confirm Z=1 after the final SUB.
3. Shift/logic: r0=0x15, SHL by 3 -> 0xA8; XOR 0xFF -> 0x57; SHR 1 -> 0x2B; AND/OR against 0x0F checked via ST.
4. Memory-count program: dm[0..31]=8'b01010101, dm[32]={5'b10101,3'b0}; program counts 5-bit pattern matches. Expected results:
   - dm[33]=64 (patterns with no byte crossing).
   - dm[34]=32 (bytes containing at least one pattern).
   - dm[35]=126 (patterns allowing byte crossing).
5. Assert req mid-loop -> next cycle PC=0, done=0, registers zero, dm preserved. The program reruns and completes normally.
6. After HALT, hold 100 cycles -> done stays 1, dm unchanged. A second req -> done drops to 0 and then rises again.
